// File: rtl/reg_dat_initiator_if.sv
// reg_dat_initiator_if: peripheral seed/data bus and the buffered output word stream
interface reg_dat_initiator_if;
  logic [3:0]  m_seed_we;
  logic [31:0] m_seed_di;
  logic        m_dat_re;
  logic [31:0] m_dat_do;
  logic        m_dat_wait;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  modport master (
    output m_seed_we, m_seed_di, m_dat_re, out_valid, out_data,
    input  m_dat_do, m_dat_wait, out_ready
  );
  modport slave (
    input  m_seed_we, m_seed_di, m_dat_re, out_valid, out_data,
    output m_dat_do, m_dat_wait, out_ready
  );
endinterface

// File: rtl/reg_dat_initiator.sv
// reg_dat_initiator: writes a seed, issues counted wait-stalled reads, buffers words in a FIFO
module reg_dat_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] seed,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        err,
  reg_dat_initiator_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CINC = 1;
  localparam logic [AW-1:0] PINC = 1;
  localparam logic [16:0]   TMO  = TIMEOUT[16:0];
  typedef enum logic [2:0] {IDLE, SEED, ISSUE, READ, DONE} state_t;
  state_t        state_q, state_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [15:0]   wait_q, wait_d;
  logic          err_reg_q, err_reg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [3:0]    m_seed_we_q, m_seed_we_d;
  logic [31:0]   m_seed_di_q, m_seed_di_d;
  logic          m_dat_re_q, m_dat_re_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    err_reg_d   = err_reg_q;
    push        = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d     = SEED;
        remaining_d = count;
        err_reg_d   = 1'b0;
      end
      SEED:  state_d = ISSUE;
      ISSUE: state_d = remaining_q == '0 ? DONE : (cnt_q != FULL ? READ : ISSUE);
      READ: if (!bus.m_dat_wait) begin
        push        = 1'b1;
        remaining_d = remaining_q - 16'd1;
        wait_d      = '0;
        state_d     = ISSUE;
      end else if ({1'b0, wait_q} + 17'd1 >= TMO) begin
        err_reg_d = 1'b1;
        wait_d    = '0;
        state_d   = DONE;
      end else begin
        wait_d = wait_q + 16'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
    err_d       = state_d == DONE && err_reg_d;
    m_seed_we_d = state_d == SEED ? 4'hF : 4'h0;
    m_seed_di_d = state_d == SEED ? seed : 32'h0;
    m_dat_re_d  = state_d == READ;
  end
  always_comb begin
    pop   = bus.out_ready && cnt_q != '0;
    wr_d  = push ? wr_q + PINC : wr_q;
    rd_d  = pop ? rd_q + PINC : rd_q;
    cnt_d = push && !pop ? cnt_q + CINC : (pop && !push ? cnt_q - CINC : cnt_q);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = bus.m_dat_do;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      err_reg_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      m_seed_we_q <= '0;
      m_seed_di_q <= '0;
      m_dat_re_q  <= 1'b0;
      mem_q       <= '{default: '0};
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      err_reg_q   <= err_reg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      m_seed_we_q <= m_seed_we_d;
      m_seed_di_q <= m_seed_di_d;
      m_dat_re_q  <= m_dat_re_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign bus.m_seed_we = m_seed_we_q;
  assign bus.m_seed_di = m_seed_di_q;
  assign bus.m_dat_re  = m_dat_re_q;
  assign bus.out_valid = cnt_q != '0;
  assign bus.out_data  = cnt_q != '0 ? mem_q[rd_q] : 32'h0;
endmodule

// File: tb/tb_reg_dat_initiator.sv
// tb_reg_dat_initiator: directed and randomized runs against a queue-based peripheral/FIFO model
module tb_reg_dat_initiator;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic [15:0] count = '0;
  logic        busy, done, err;
  reg_dat_initiator_if bus();
  reg_dat_initiator #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .seed(seed), .count(count),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int passes = 0, fails = 0, total = 0;
  logic [31:0] src[$], exp_q[$], got[$];
  int re_rise[$];
  int re_hi = 0, done_n = 0, done_cyc = 0, we_n = 0, we_cyc = 0, t0 = 0;
  logic done_err = 1'b0;
  logic [31:0] we_di = '0;
  logic [3:0] we_be = '0;
  int stall_n = 0, st = 0, tgt = 0;
  bit stuck = 0, rnd_stall = 0, rnd_rdy = 0;
  logic re_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.m_dat_re === 1'b1) begin
      if (!re_prev) begin
        st  = 0;
        tgt = rnd_stall ? int'($urandom_range(0, 5)) : stall_n;
        re_rise.push_back(cyc);
      end
      if (stuck || st < tgt) begin
        bus.m_dat_wait = 1'b1;
        bus.m_dat_do   = $urandom;
        st++;
      end else begin
        bus.m_dat_wait = 1'b0;
        if (src.size() != 0) bus.m_dat_do = src.pop_front();
        else bus.m_dat_do = 32'hBAD0BAD0;
      end
      re_hi++;
    end else begin
      bus.m_dat_wait = 1'($urandom_range(0, 1));
      bus.m_dat_do   = $urandom;
    end
    re_prev = bus.m_dat_re === 1'b1;
    if (bus.m_seed_we !== 4'h0) begin
      we_n++;
      we_cyc = cyc;
      we_be  = bus.m_seed_we;
      we_di  = bus.m_seed_di;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
      done_err = err;
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
  end
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    re_rise.delete();
    got.delete();
    exp_q.delete();
    re_hi = 0;
    done_n = 0;
    we_n = 0;
  endtask
  task automatic fill(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back($urandom);
    exp_q = src;
  endtask
  task automatic run_start(input logic [31:0] s, input logic [15:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    seed  = s;
    count = n;
    t0    = cyc;
    tick(1);
    start = 1'b0;
    seed  = $urandom;
    count = 16'($urandom);
  endtask
  task automatic wait_done(input int lim);
    int n = 0;
    while (done_n == 0 && n < lim) begin
      tick(1);
      n++;
    end
    chk("done_seen", 32'(done_n != 0), 32'd1);
  endtask
  task automatic drain();
    int n = 0;
    rnd_rdy = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid === 1'b1 && n < 100) begin
      tick(1);
      bus.out_ready = 1'b1;
      n++;
    end
    chk("drained", 32'(bus.out_valid), 32'd0);
  endtask
  task automatic chk_words(input int n);
    chk("nwords", got.size(), n);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk("word", got[i], exp_q[i]);
  endtask
  initial begin
    bus.out_ready = 1'b0;
    tick(3);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_outs", 32'({busy, done, err, bus.m_dat_re, bus.out_valid,
                            |bus.m_seed_we, |bus.m_seed_di, |bus.out_data}), 32'd0);
    end
    chk("idle_no_bus", 32'(re_rise.size() + we_n), 32'd0);
    clr();
    run_start(32'hDEADBEEF, 16'd0);
    chk("seed_we", bus.m_seed_we, 32'hF);
    chk("seed_di", bus.m_seed_di, 32'hDEADBEEF);
    chk("busy_t1", 32'(busy), 32'd1);
    wait_done(20);
    chk("c0_done_cyc", done_cyc, t0 + 3);
    chk("c0_err", 32'(done_err), 32'd0);
    chk("c0_no_re", re_rise.size(), 32'd0);
    chk("c0_we_once", we_n, 32'd1);
    chk("c0_we_cyc", we_cyc, t0 + 1);
    tick(1);
    chk("c0_busy_off", 32'(busy), 32'd0);
    clr();
    src = '{32'h11, 32'h22, 32'h33};
    exp_q = src;
    bus.out_ready = 1'b1;
    run_start($urandom, 16'd3);
    wait_done(40);
    chk("c3_nrise", re_rise.size(), 32'd3);
    for (int i = 0; i < re_rise.size() && i < 3; i++) chk("c3_rise_cyc", re_rise[i], t0 + 3 + 2 * i);
    chk("c3_done_cyc", done_cyc, t0 + 9);
    chk("c3_err", 32'(done_err), 32'd0);
    drain();
    chk_words(3);
    clr();
    fill(6);
    bus.out_ready = 1'b0;
    run_start($urandom, 16'd6);
    tick(30);
    chk("bp_nrise", re_rise.size(), 32'd4);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    wait_done(60);
    chk("bp_err", 32'(done_err), 32'd0);
    drain();
    chk("bp_nrise_all", re_rise.size(), 32'd6);
    chk_words(6);
    clr();
    fill(2);
    stall_n = 5;
    run_start($urandom, 16'd2);
    tick(4);
    start = 1'b1;
    count = 16'd9;
    tick(1);
    start = 1'b0;
    wait_done(60);
    chk("st_re_hi", re_hi, 32'd12);
    chk("st_nrise", re_rise.size(), 32'd2);
    chk("st_done_cyc", done_cyc, t0 + 17);
    chk("st_err", 32'(done_err), 32'd0);
    chk("st_start_ignored", we_n, 32'd1);
    drain();
    chk_words(2);
    stall_n = 0;
    clr();
    fill(3);
    stuck = 1;
    bus.out_ready = 1'b0;
    run_start($urandom, 16'd3);
    wait_done(60);
    chk("to_re_hi", re_hi, 32'd8);
    chk("to_done_cyc", done_cyc, t0 + 11);
    chk("to_err", 32'(done_err), 32'd1);
    chk("to_fifo_empty", 32'(bus.out_valid), 32'd0);
    chk("to_no_words", got.size(), 32'd0);
    chk("to_re_low", 32'(bus.m_dat_re), 32'd0);
    stuck = 0;
    clr();
    fill(5);
    stall_n = 3;
    run_start($urandom, 16'd5);
    for (int n = 0; re_rise.size() < 3 && n < 60; n++) tick(1);
    chk("rs_in_read", 32'(bus.m_dat_re), 32'd1);
    chk("rs_fifo_full_before", 32'(bus.out_valid), 32'd1);
    resetn = 1'b0;
    tick(1);
    chk("rs_re", 32'(bus.m_dat_re), 32'd0);
    chk("rs_fifo", 32'(bus.out_valid), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick(20);
    chk("rs_no_done", done_n, 32'd0);
    stall_n = 0;
    rnd_stall = 1;
    for (int r = 0; r < 6; r++) begin
      int n;
      clr();
      n = int'($urandom_range(0, 9));
      fill(n);
      rnd_rdy = 1;
      run_start($urandom, 16'(n));
      wait_done(400);
      chk("rnd_err", 32'(done_err), 32'd0);
      chk("rnd_nrise", re_rise.size(), n);
      drain();
      chk("rnd_done_once", done_n, 32'd1);
      chk_words(n);
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
